lsq_dcache_arbiter: RTL and testbench

- Shares the data-cache request ports between committed stores from the store queue and issued loads from the load queue.
- Each cycle it packs up to NUM_PORTS requests onto the ports and returns per-requester accepts.
- Store ordering is preserved. Loads rotate round-robin.
- A starvation counter and sq_almost_full give stores priority when needed, so the store queue always drains.

---
 rtl/lsq_dcache_arbiter_pkg.sv | 22 ++
 rtl/lsq_dcache_arbiter_rr_picker.sv | 51 +++++
 rtl/lsq_dcache_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_lsq_dcache_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_dcache_arbiter_pkg.sv
// Shared types and defaults for the LSQ / data-cache request arbiter.
package lsq_dcache_arbiter_pkg;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TAG_W        = 3;

    typedef enum logic {
        LOAD_PRI  = 1'b0,
        STORE_PRI = 1'b1
    } arb_mode_e;

    // The packet tag field is DEF_TAG_W wide; raise it together with TAG_W.
    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [2:0]           func;
        logic [DEF_TAG_W-1:0] tag;
    } dcache_req_packet_t;

endpackage

// File: rtl/lsq_dcache_arbiter_rr_picker.sv
// Rotating-priority encoder: lists the valid request indices in order,
// starting at ptr and wrapping modulo N.
module lsq_dcache_arbiter_rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         valid,
    input  logic [IW-1:0]        ptr,
    output logic [N-1:0][IW-1:0] order_idx,
    output logic [N-1:0]         order_vld,
    output logic [IW:0]          count
);

    logic [N-1:0][IW-1:0] rot_idx;
    logic [N-1:0]         rot_valid;
    logic [IW:0]          pos [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum            = {1'b0, ptr} + (IW+1)'(gi);
            assign rot_idx[gi]    = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
            assign rot_valid[gi]  = valid[rot_idx[gi]];
        end
    endgenerate

    // Position of each rotated slot among the valid ones (running prefix count).
    always_comb begin
        logic [IW:0] run;
        run = '0;
        for (int r = 0; r < N; r++) begin
            pos[r] = run;
            run    = run + (IW+1)'(rot_valid[r]);
        end
        count = run;
    end

    always_comb begin
        order_idx = '0;
        order_vld = '0;
        for (int q = 0; q < N; q++) begin
            for (int r = 0; r < N; r++) begin
                if (rot_valid[r] && (pos[r] == (IW+1)'(q))) begin
                    order_idx[q] = rot_idx[r];
                    order_vld[q] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lsq_dcache_arbiter.sv
// Packs committed stores and issued loads onto the dcache request ports.
// Optional grant/starvation counters are built when LSQ_ARB_PERF_EN is defined.
module lsq_dcache_arbiter
    import lsq_dcache_arbiter_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int NUM_ST       = 2,
    parameter int NUM_LD       = 2,
    parameter int TAG_W        = DEF_TAG_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       sq_almost_full,
    input  logic [NUM_ST-1:0]          st_valid,
    input  logic [NUM_ST*32-1:0]       st_addr,
    input  logic [NUM_ST*32-1:0]       st_data,
    input  logic [NUM_ST*3-1:0]        st_func,
    output logic [NUM_ST-1:0]          st_accept,
    input  logic [NUM_LD-1:0]          ld_valid,
    input  logic [NUM_LD*32-1:0]       ld_addr,
    input  logic [NUM_LD*3-1:0]        ld_func,
    input  logic [NUM_LD*TAG_W-1:0]    ld_tag,
    output logic [NUM_LD-1:0]          ld_accept,
    output logic [NUM_PORTS-1:0]       port_valid,
    output logic [NUM_PORTS-1:0]       port_is_store,
    output logic [NUM_PORTS*32-1:0]    port_addr,
    output logic [NUM_PORTS*32-1:0]    port_data,
    output logic [NUM_PORTS*3-1:0]     port_func,
    output logic [NUM_PORTS*TAG_W-1:0] port_tag,
    input  logic [NUM_PORTS-1:0]       port_ready,
`ifdef LSQ_ARB_PERF_EN
    output logic [31:0]                perf_ld_grants,
    output logic [31:0]                perf_st_grants,
    output logic [31:0]                perf_st_starve_cycles,
`endif
    output logic                       store_pri
);

    localparam int LIW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
    localparam int SRW = $clog2(NUM_ST + 1);
    localparam int CW  = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;

    arb_mode_e           mode_q, mode_d;
    logic [CW-1:0]       starve_q, starve_d;
    logic [LIW-1:0]      rr_ptr_q, rr_ptr_d;

    logic                      store_first;
    logic [NUM_LD-1:0][LIW-1:0] ld_order_idx;
    logic [NUM_LD-1:0]         ld_order_vld;
    logic [LIW:0]              ld_cnt;
    logic [SRW-1:0]            st_rank [NUM_ST];
    logic [SRW-1:0]            st_cnt;
    logic [NUM_ST-1:0]         st_ready;
    logic [NUM_ST-1:0]         st_acc;
    logic [NUM_LD-1:0]         ld_acc;
    logic                      starve_inc;
    dcache_req_packet_t        pkt [NUM_PORTS];

    assign store_first = (mode_q == STORE_PRI) || sq_almost_full;

    // A squash removes loads from the candidate set so stores take every port.
    lsq_dcache_arbiter_rr_picker #(.N(NUM_LD), .IW(LIW)) u_rr_picker (
        .valid     (ld_valid & {NUM_LD{~squash}}),
        .ptr       (rr_ptr_q),
        .order_idx (ld_order_idx),
        .order_vld (ld_order_vld),
        .count     (ld_cnt)
    );

    always_comb begin
        logic [SRW-1:0] run;
        run = '0;
        for (int j = 0; j < NUM_ST; j++) begin
            st_rank[j] = run;
            run        = run + SRW'(st_valid[j]);
        end
        st_cnt = run;
    end

    always_comb begin
        int st_base;
        int ld_base;
        st_base  = store_first ? 0 : int'(ld_cnt);
        ld_base  = store_first ? int'(st_cnt) : 0;
        st_ready = '0;
        ld_acc   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pkt[p] = '0;
            for (int j = 0; j < NUM_ST; j++) begin
                if (st_valid[j] && (st_base + int'(st_rank[j]) == p)) begin
                    pkt[p].valid    = 1'b1;
                    pkt[p].is_store = 1'b1;
                    pkt[p].addr     = st_addr[j*32 +: 32];
                    pkt[p].data     = st_data[j*32 +: 32];
                    pkt[p].func     = st_func[j*3 +: 3];
                    st_ready[j]     = port_ready[p];
                end
            end
            for (int r = 0; r < NUM_LD; r++) begin
                if (ld_order_vld[r] && (ld_base + r == p)) begin
                    for (int k = 0; k < NUM_LD; k++) begin
                        if (int'(ld_order_idx[r]) == k) begin
                            pkt[p].valid = 1'b1;
                            pkt[p].addr  = ld_addr[k*32 +: 32];
                            pkt[p].func  = ld_func[k*3 +: 3];
                            pkt[p].tag   = DEF_TAG_W'(ld_tag[k*TAG_W +: TAG_W]);
                            ld_acc[k]    = port_ready[p];
                        end
                    end
                end
            end
        end
    end

    // Stores commit in order: the first refused valid store blocks all younger ones.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        st_acc  = '0;
        for (int j = 0; j < NUM_ST; j++) begin
            if (st_valid[j]) begin
                if (!blocked && st_ready[j]) st_acc[j] = 1'b1;
                else                         blocked   = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (squash) begin
            rr_ptr_d = '0;
        end else begin
            for (int r = 0; r < NUM_LD; r++) begin
                if (ld_order_vld[r] && ld_acc[ld_order_idx[r]]) begin
                    rr_ptr_d = (int'(ld_order_idx[r]) + 1 >= NUM_LD) ? '0 : ld_order_idx[r] + 1'b1;
                end
            end
        end
    end

    assign starve_inc = (|st_valid) && !(|st_acc);

    always_comb begin
        mode_d   = mode_q;
        starve_d = starve_q;
        if (starve_inc) begin
            if ((mode_q == LOAD_PRI) && (int'(starve_q) + 1 >= STARVE_LIMIT)) begin
                mode_d   = STORE_PRI;
                starve_d = '0;
            end else if (int'(starve_q) < STARVE_LIMIT - 1) begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            mode_d   = LOAD_PRI;
            starve_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q   <= LOAD_PRI;
            starve_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_valid[gi]               = !reset && pkt[gi].valid;
            assign port_is_store[gi]            = !reset && pkt[gi].is_store;
            assign port_addr[gi*32 +: 32]       = reset ? '0 : pkt[gi].addr;
            assign port_data[gi*32 +: 32]       = reset ? '0 : pkt[gi].data;
            assign port_func[gi*3 +: 3]         = reset ? '0 : pkt[gi].func;
            assign port_tag[gi*TAG_W +: TAG_W]  = reset ? '0 : TAG_W'(pkt[gi].tag);
        end
    endgenerate

    assign st_accept = reset ? '0 : st_acc;
    assign ld_accept = reset ? '0 : ld_acc;
    assign store_pri = (mode_q == STORE_PRI);

`ifdef LSQ_ARB_PERF_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    always_comb begin
        perf_ld_d     = perf_ld_q + 32'($countones(ld_acc));
        perf_st_d     = perf_st_q + 32'($countones(st_acc));
        perf_starve_d = perf_starve_q + 32'(starve_inc);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_ld_q     <= '0;
            perf_st_q     <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_ld_q     <= perf_ld_d;
            perf_st_q     <= perf_st_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_ld_grants        = perf_ld_q;
    assign perf_st_grants        = perf_st_q;
    assign perf_st_starve_cycles = perf_starve_q;
`endif

endmodule

// File: tb/tb_lsq_dcache_arbiter.sv
// Directed bench for lsq_dcache_arbiter with a queue-based reference model.
module tb_lsq_dcache_arbiter;

    localparam int NP = 2;
    localparam int NS = 2;
    localparam int NL = 2;
    localparam int TW = 3;
    localparam int LIMIT = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic              sq_almost_full;
    logic [NS-1:0]     st_valid;
    logic [NS*32-1:0]  st_addr;
    logic [NS*32-1:0]  st_data;
    logic [NS*3-1:0]   st_func;
    logic [NS-1:0]     st_accept;
    logic [NL-1:0]     ld_valid;
    logic [NL*32-1:0]  ld_addr;
    logic [NL*3-1:0]   ld_func;
    logic [NL*TW-1:0]  ld_tag;
    logic [NL-1:0]     ld_accept;
    logic [NP-1:0]     port_valid;
    logic [NP-1:0]     port_is_store;
    logic [NP*32-1:0]  port_addr;
    logic [NP*32-1:0]  port_data;
    logic [NP*3-1:0]   port_func;
    logic [NP*TW-1:0]  port_tag;
    logic [NP-1:0]     port_ready;
    logic              store_pri;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    lsq_dcache_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .sq_almost_full (sq_almost_full),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_func        (st_func),
        .st_accept      (st_accept),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_func        (ld_func),
        .ld_tag         (ld_tag),
        .ld_accept      (ld_accept),
        .port_valid     (port_valid),
        .port_is_store  (port_is_store),
        .port_addr      (port_addr),
        .port_data      (port_data),
        .port_func      (port_func),
        .port_tag       (port_tag),
        .port_ready     (port_ready),
        .store_pri      (store_pri)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, step_no, act, exp);
        end
    endtask

    // Reference model state: mode (0 load-first, 1 store-first), starvation count, rotation pointer.
    int m_mode = 0, m_starve = 0, m_rr = 0;
    int n_mode = 0, n_starve = 0, n_rr = 0;

    always @(negedge clock) begin : model_cmp
        int sts[$];
        int lds[$];
        int ent_st[$];
        int ent_idx[$];
        logic [NP-1:0]    e_pv, e_ps;
        logic [NP*32-1:0] e_pa, e_pd;
        logic [NP*3-1:0]  e_pf;
        logic [NP*TW-1:0] e_pt;
        logic [NS-1:0]    e_sa, st_ok;
        logic [NL-1:0]    e_la;
        logic             blocked;
        int               k;
        e_pv = '0; e_ps = '0; e_pa = '0; e_pd = '0; e_pf = '0; e_pt = '0;
        e_sa = '0; e_la = '0; st_ok = '0;
        sts.delete(); lds.delete(); ent_st.delete(); ent_idx.delete();
        if (reset) begin
            n_mode = 0; n_starve = 0; n_rr = 0;
        end else begin
            for (int j = 0; j < NS; j++) if (st_valid[j]) sts.push_back(j);
            if (!squash) begin
                for (int r = 0; r < NL; r++) begin
                    k = (m_rr + r) % NL;
                    if (ld_valid[k]) lds.push_back(k);
                end
            end
            if (m_mode == 1 || sq_almost_full) begin
                foreach (sts[i]) begin ent_st.push_back(1); ent_idx.push_back(sts[i]); end
                foreach (lds[i]) begin ent_st.push_back(0); ent_idx.push_back(lds[i]); end
            end else begin
                foreach (lds[i]) begin ent_st.push_back(0); ent_idx.push_back(lds[i]); end
                foreach (sts[i]) begin ent_st.push_back(1); ent_idx.push_back(sts[i]); end
            end
            for (int p = 0; p < NP; p++) begin
                if (p < ent_st.size()) begin
                    k = ent_idx[p];
                    e_pv[p] = 1'b1;
                    if (ent_st[p] == 1) begin
                        e_ps[p] = 1'b1;
                        e_pa[p*32 +: 32] = st_addr[k*32 +: 32];
                        e_pd[p*32 +: 32] = st_data[k*32 +: 32];
                        e_pf[p*3 +: 3]   = st_func[k*3 +: 3];
                        st_ok[k] = port_ready[p];
                    end else begin
                        e_pa[p*32 +: 32] = ld_addr[k*32 +: 32];
                        e_pf[p*3 +: 3]   = ld_func[k*3 +: 3];
                        e_pt[p*TW +: TW] = ld_tag[k*TW +: TW];
                        e_la[k] = port_ready[p];
                    end
                end
            end
            blocked = 1'b0;
            foreach (sts[i]) begin
                if (!blocked && st_ok[sts[i]]) e_sa[sts[i]] = 1'b1;
                else blocked = 1'b1;
            end
            if (sts.size() > 0 && e_sa == '0) begin
                if (m_mode == 0 && m_starve + 1 >= LIMIT) begin
                    n_mode = 1; n_starve = 0;
                end else begin
                    n_mode = m_mode;
                    n_starve = (m_starve + 1 > LIMIT - 1) ? LIMIT - 1 : m_starve + 1;
                end
            end else begin
                n_mode = 0; n_starve = 0;
            end
            if (squash) n_rr = 0;
            else begin
                n_rr = m_rr;
                foreach (lds[i]) if (e_la[lds[i]]) n_rr = (lds[i] + 1) % NL;
            end
        end
        chk("port_valid",    64'(port_valid),    64'(e_pv));
        chk("port_is_store", 64'(port_is_store), 64'(e_ps));
        chk("port_addr",     64'(port_addr),     64'(e_pa));
        chk("port_data",     64'(port_data),     64'(e_pd));
        chk("port_func",     64'(port_func),     64'(e_pf));
        chk("port_tag",      64'(port_tag),      64'(e_pt));
        chk("st_accept",     64'(st_accept),     64'(e_sa));
        chk("ld_accept",     64'(ld_accept),     64'(e_la));
        chk("store_pri",     64'(store_pri),     (reset || m_mode == 0) ? 64'd0 : 64'd1);
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_starve <= 0; m_rr <= 0;
        end else begin
            m_mode <= n_mode; m_starve <= n_starve; m_rr <= n_rr;
        end
    end

    task automatic apply(input logic [1:0] sv, input logic [1:0] lv, input logic [1:0] rdy,
                         input logic af, input logic sq);
        @(posedge clock);
        #1;
        st_valid = sv; ld_valid = lv; port_ready = rdy;
        sq_almost_full = af; squash = sq;
        step_no++;
        $display("step %0d: st_valid=%b ld_valid=%b port_ready=%b af=%b squash=%b",
                 step_no, sv, lv, rdy, af, sq);
        #2;
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; sq_almost_full = 1'b0;
        st_addr = {32'h0000_0104, 32'h0000_0100};
        st_data = {32'hBBBB_0001, 32'hAAAA_0000};
        st_func = {3'd1, 3'd2};
        ld_addr = {32'h0000_0300, 32'h0000_0200};
        ld_func = {3'd0, 3'd4};
        ld_tag  = {3'd2, 3'd5};
        st_valid = 2'b01; ld_valid = 2'b11; port_ready = 2'b11;
        #3;
        chk("reset_port_valid", 64'(port_valid), 64'd0);
        chk("reset_ld_accept",  64'(ld_accept),  64'd0);
        chk("reset_store_pri",  64'(store_pri),  64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        st_valid = 2'b00; ld_valid = 2'b00;
        reset = 1'b0;

        apply(2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("idle_port_valid", 64'(port_valid), 64'b11);
        chk("idle_is_store",   64'(port_is_store), 64'b00);
        chk("idle_ld_accept",  64'(ld_accept), 64'b11);
        chk("idle_port_tag",   64'(port_tag), 64'({3'd2, 3'd5}));

        apply(2'b01, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("mix_st_accept", 64'(st_accept), 64'b00);
        chk("mix_is_store",  64'(port_is_store), 64'b00);
        repeat (3) apply(2'b01, 2'b11, 2'b11, 1'b0, 1'b0);

        apply(2'b01, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("starve_store_pri", 64'(store_pri), 64'd1);
        chk("spri_is_store",    64'(port_is_store), 64'b01);
        chk("spri_port_addr",   64'(port_addr), {32'h0000_0200, 32'h0000_0100});
        chk("spri_st_accept",   64'(st_accept), 64'b01);
        chk("spri_ld_accept",   64'(ld_accept), 64'b01);

        apply(2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("back_store_pri", 64'(store_pri), 64'd0);
        chk("rot_port_tag",   64'(port_tag), 64'({3'd5, 3'd2}));

        apply(2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        chk("order_port_valid", 64'(port_valid), 64'b11);
        chk("order_is_store",   64'(port_is_store), 64'b11);
        chk("order_st_accept",  64'(st_accept), 64'b00);

        apply(2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
        chk("prefix_st_accept", 64'(st_accept), 64'b01);

        apply(2'b11, 2'b11, 2'b11, 1'b1, 1'b0);
        chk("af_is_store",  64'(port_is_store), 64'b11);
        chk("af_ld_accept", 64'(ld_accept), 64'b00);
        chk("af_st_accept", 64'(st_accept), 64'b11);

        apply(2'b00, 2'b01, 2'b11, 1'b0, 1'b0);
        chk("af_mode_kept", 64'(store_pri), 64'd0);
        chk("rr1_port_tag", 64'(port_tag[2:0]), 64'd5);
        chk("rr1_ld_accept", 64'(ld_accept), 64'b01);

        apply(2'b01, 2'b11, 2'b11, 1'b0, 1'b1);
        chk("sq_port_valid", 64'(port_valid), 64'b01);
        chk("sq_is_store",   64'(port_is_store), 64'b01);
        chk("sq_ld_accept",  64'(ld_accept), 64'b00);
        chk("sq_st_accept",  64'(st_accept), 64'b01);

        apply(2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("sq_rr_reset_tag", 64'(port_tag), 64'({3'd2, 3'd5}));

        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        chk("nordy_ld_accept", 64'(ld_accept), 64'b00);
        chk("nordy_st_accept", 64'(st_accept), 64'b00);
        repeat (3) apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        chk("nordy_store_pri", 64'(store_pri), 64'd1);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);

        reset = 1'b1;
        #1;
        chk("midrst_port_valid", 64'(port_valid), 64'd0);
        chk("midrst_store_pri",  64'(store_pri), 64'd0);
        chk("midrst_port_addr",  64'(port_addr), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        chk("postrst_load_pri", 64'(store_pri), 64'd0);
        apply(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        chk("postrst_store_pri", 64'(store_pri), 64'd1);

        apply(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        apply(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
